// File: rtl/pc_fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: program counter, instruction-memory addressing,
// range/alignment guard and predecode of rs/rt/rd plus Tuse/Tnew for the IF/ID register.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IM_AW    = 10
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_rdata,
  output logic [31:0]      pc_IF,
  output logic [31:0]      ins_IF,
  output logic [1:0]       Tuse_IF,
  output logic [1:0]       Tnew_IF,
  output logic [4:0]       rs_IF,
  output logic [4:0]       rt_IF,
  output logic [4:0]       rd_IF,
  output logic             pc_err,
  output logic [31:0]      fetch_cnt
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;

  // True when pc is word aligned and inside RESET_PC .. RESET_PC + 4*2^IM_AW - 1.
  function automatic logic f_in_range(input logic [31:0] pc);
    logic [31:0] off;
    off = pc - RESET_PC;
    return (pc >= RESET_PC) && ((off >> (IM_AW + 2)) == 32'd0) && (pc[1:0] == 2'b00);
  endfunction

  logic [31:0] r_pc;
  logic        r_pc_err;
  logic [31:0] r_fetch_cnt;

  logic [31:0] w_pc_next;
  logic [31:0] w_offset;
  logic        w_in_range;
  logic        w_next_in_range;

  // Flow control: stall holds the PC and beats a same-cycle redirect, which is
  // simply dropped (ID re-asserts it); every unstalled edge issues one word.
  always_comb begin
    w_pc_next = r_pc;
    if (!stall) begin
      w_pc_next = redirect ? redirect_pc : r_pc + 32'd4;
    end
  end

  assign w_offset        = r_pc - RESET_PC;
  assign w_in_range      = f_in_range(r_pc);
  assign w_next_in_range = f_in_range(w_pc_next);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_pc        <= RESET_PC;
      r_pc_err    <= 1'b0;
      r_fetch_cnt <= 32'd0;
    end else begin
      r_pc <= w_pc_next;
      // Sticky: set on the edge that lands pc out of range, cleared only by reset.
      if (!w_next_in_range) begin
        r_pc_err <= 1'b1;
      end
      if (!stall) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
    end
  end

  assign pc_IF     = r_pc;
  assign pc_err    = r_pc_err;
  assign fetch_cnt = r_fetch_cnt;
  assign im_addr   = IM_AW'(w_offset >> 2);
  assign ins_IF    = (w_in_range && !r_pc_err) ? im_rdata : 32'd0;
  assign rs_IF     = ins_IF[25:21];
  assign rt_IF     = ins_IF[20:16];

  always_comb begin
    Tuse_IF = 2'd3;
    Tnew_IF = 2'd0;
    rd_IF   = 5'd0;
    case (ins_IF[31:26])
      OP_SPECIAL: begin
        case (ins_IF[5:0])
          FN_ADDU, FN_SUBU: begin
            Tuse_IF = 2'd1;
            Tnew_IF = 2'd1;
            rd_IF   = ins_IF[15:11];
          end
          FN_JR: begin
            Tuse_IF = 2'd0;
          end
          default: begin
          end
        endcase
      end
      OP_ORI: begin
        Tuse_IF = 2'd1;
        Tnew_IF = 2'd1;
        rd_IF   = ins_IF[20:16];
      end
      OP_LUI: begin
        Tnew_IF = 2'd1;
        rd_IF   = ins_IF[20:16];
      end
      OP_LW: begin
        Tuse_IF = 2'd1;
        Tnew_IF = 2'd2;
        rd_IF   = ins_IF[20:16];
      end
      OP_SW: begin
        Tuse_IF = 2'd1;
      end
      OP_BEQ: begin
        Tuse_IF = 2'd0;
      end
      OP_J: begin
      end
      OP_JAL: begin
        rd_IF = 5'd31;
      end
      default: begin
      end
    endcase
  end

endmodule
